pipe_front_ctrl: RTL and testbench

PIPE_FRONT_CTRL -- requirements
Module: pipe_front_ctrl

---
 rtl/pipe_pkg.sv | 17 +
 rtl/pc_next_sel.sv | 26 ++
 rtl/pipe_front_ctrl.sv | 111 +++++++++++
 tb/tb_pipe_front_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline front end: FSM encoding, default NOP word
// and the control-flow opcode constants used by the decoder side.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    REDIR = 2'd2
  } pipe_state_e;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selector: branch target, pseudo-direct jump target,
// sequential PC+4 (wrapping mod 2^32) or hold.
module pc_next_sel (
  input  logic [31:0] pc,
  input  logic        pc_en,
  input  logic        redirect,
  input  logic        branch_not_jump,
  input  logic [31:0] branch_target,
  input  logic [3:0]  jump_region,
  input  logic [25:0] jump_index,
  output logic [31:0] pc_next
);

  // A redirect resolved in EX is older than a stall in ID, so it is checked
  // before pc_en.
  always_comb begin
    pc_next = pc;
    if (redirect) begin
      if (branch_not_jump) pc_next = branch_target;
      else                 pc_next = {jump_region, jump_index, 2'b00};
    end else if (pc_en) begin
      pc_next = pc + 32'd4;
    end
  end

endmodule

// File: rtl/pipe_front_ctrl.sv
// Pipeline front end: PC register, IF/ID register, ID/EX bubble flag, hazard FSM
// and sticky protocol-error flag. Define PIPE_PERF_CNT_EN for stall/flush counters.
module pipe_front_ctrl
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_en,
  input  logic        if_id_en,
  input  logic        ctrl_sel,
  input  logic        instr_sel,
  input  logic        redirect,
  input  logic        branch_not_jump,
  input  logic [31:0] branch_target,
  input  logic [31:0] imem_data,
  output logic [31:0] imem_addr,
  output logic [31:0] if_id_ir,
  output logic [31:0] if_id_pc4,
  output logic        id_ex_valid,
  output logic [1:0]  state,
`ifdef PIPE_PERF_CNT_EN
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
`endif
  output logic        proto_err
);

  logic [31:0] pc_q;
  logic [31:0] pc_next;
  logic [31:0] pc_plus4;
  pipe_state_e state_q;
  pipe_state_e state_next;

  assign pc_plus4  = pc_q + 32'd4;
  assign imem_addr = pc_q;

  pc_next_sel u_pc_next_sel (
    .pc              (pc_q),
    .pc_en           (pc_en),
    .redirect        (redirect),
    .branch_not_jump (branch_not_jump),
    .branch_target   (branch_target),
    .jump_region     (if_id_pc4[31:28]),
    .jump_index      (if_id_ir[25:0]),
    .pc_next         (pc_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_next;
  end

  // Squash wins over a plain IF/ID hold; both use the current PC for pc4.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if_id_ir  <= NOP_INSTR;
      if_id_pc4 <= RESET_PC;
    end else if (instr_sel || redirect) begin
      if_id_ir  <= NOP_INSTR;
      if_id_pc4 <= pc_plus4;
    end else if (if_id_en) begin
      if_id_ir  <= imem_data;
      if_id_pc4 <= pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) id_ex_valid <= 1'b0;
    else        id_ex_valid <= !ctrl_sel && !(redirect && branch_not_jump);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_next;
  end

  always_comb begin
    state_next = RUN;
    if (redirect)    state_next = REDIR;
    else if (!pc_en) state_next = STALL;
  end

  always_comb begin
    state = state_q;
  end

  // Stalling the PC while IF/ID still loads, or redirecting without squashing
  // the wrong-path fetch, means the hazard unit is broken; latch it until reset.
  always_ff @(posedge clk) begin
    if (!rst_n)
      proto_err <= 1'b0;
    else if ((!pc_en && if_id_en) || (redirect && !instr_sel))
      proto_err <= 1'b1;
  end

`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (state_q == STALL && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
      if (redirect && flush_cnt != 32'hFFFF_FFFF)         flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_front_ctrl.sv
// Bench for pipe_front_ctrl: directed vector table, hand-written corner sequences,
// then random traffic compared against a behavioural model.
module tb_pipe_front_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n, pc_en, if_id_en, ctrl_sel, instr_sel, redirect, branch_not_jump;
  logic [31:0] branch_target, imem_data;
  logic [31:0] imem_addr, if_id_ir, if_id_pc4;
  logic        id_ex_valid, proto_err;
  logic [1:0]  state;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_front_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pc_en           (pc_en),
    .if_id_en        (if_id_en),
    .ctrl_sel        (ctrl_sel),
    .instr_sel       (instr_sel),
    .redirect        (redirect),
    .branch_not_jump (branch_not_jump),
    .branch_target   (branch_target),
    .imem_data       (imem_data),
    .imem_addr       (imem_addr),
    .if_id_ir        (if_id_ir),
    .if_id_pc4       (if_id_pc4),
    .id_ex_valid     (id_ex_valid),
    .state           (state),
`ifdef PIPE_PERF_CNT_EN
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt),
`endif
    .proto_err       (proto_err)
  );

  typedef struct {
    logic        rst_n, pc_en, if_id_en, ctrl_sel, instr_sel, redirect, bnj;
    logic [31:0] target, imem;
    logic [31:0] exp_pc, exp_ir, exp_pc4;
    logic        exp_valid;
    logic [1:0]  exp_state;
    logic        exp_err;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(input logic r, pe, ie, cs, is, rd, bj,
                              input logic [31:0] tg, im, pc, ir, p4,
                              input logic v, input logic [1:0] st, input logic er);
    vec_t x;
    x.rst_n = r; x.pc_en = pe; x.if_id_en = ie; x.ctrl_sel = cs; x.instr_sel = is;
    x.redirect = rd; x.bnj = bj; x.target = tg; x.imem = im;
    x.exp_pc = pc; x.exp_ir = ir; x.exp_pc4 = p4;
    x.exp_valid = v; x.exp_state = st; x.exp_err = er;
    return x;
  endfunction

  task automatic applyStimulus(input logic r, pe, ie, cs, is, rd, bj,
                               input logic [31:0] tg, im);
    rst_n = r; pc_en = pe; if_id_en = ie; ctrl_sel = cs; instr_sel = is;
    redirect = rd; branch_not_jump = bj; branch_target = tg; imem_data = im;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model state, written from the functional rules.
  logic [31:0] m_pc, m_ir, m_pc4, m_stall, m_flush;
  logic        m_valid, m_err;
  int          m_mode;

  task automatic modelStep(input logic r, pe, ie, cs, is, rd, bj,
                           input logic [31:0] tg, im);
    logic [31:0] cur_pc;
    cur_pc = m_pc;
    if (!r) begin
      m_pc = 32'h0; m_ir = NOP; m_pc4 = 32'h0; m_valid = 0; m_mode = 0;
      m_err = 0; m_stall = 0; m_flush = 0;
      return;
    end
    if (m_mode == 1 && m_stall != 32'hFFFF_FFFF) m_stall++;
    if (rd && m_flush != 32'hFFFF_FFFF) m_flush++;
    if (rd && bj)       m_pc = tg;
    else if (rd)        m_pc = {m_pc4[31:28], m_ir[25:0], 2'b00};
    else if (pe)        m_pc = cur_pc + 4;
    if (is || rd)       begin m_ir = NOP; m_pc4 = cur_pc + 4; end
    else if (ie)        begin m_ir = im;  m_pc4 = cur_pc + 4; end
    m_valid = !cs && !(rd && bj);
    m_mode  = rd ? 2 : (!pe ? 1 : 0);
    if ((!pe && ie) || (rd && !is)) m_err = 1;
  endtask

  initial begin
    rst_n = 0; pc_en = 1; if_id_en = 1; ctrl_sel = 0; instr_sel = 0;
    redirect = 0; branch_not_jump = 0; branch_target = 0; imem_data = 0;

    //               r  pe ie cs is rd bj target        imem          pc            ir            pc4           v  st    er
    vecs[0]  = mk(0, 1, 1, 0, 0, 0, 0, 32'h0,        32'h2008_0005, 32'h0,        NOP,          32'h0,        0, 2'd0, 0);
    vecs[1]  = mk(0, 1, 1, 0, 0, 0, 0, 32'h0,        32'h2008_0005, 32'h0,        NOP,          32'h0,        0, 2'd0, 0);
    vecs[2]  = mk(1, 1, 1, 0, 0, 0, 0, 32'h0,        32'h2008_0005, 32'h4,        32'h2008_0005, 32'h4,       1, 2'd0, 0);
    vecs[3]  = mk(1, 1, 1, 0, 0, 0, 0, 32'h0,        32'h2008_0005, 32'h8,        32'h2008_0005, 32'h8,       1, 2'd0, 0);
    vecs[4]  = mk(1, 1, 1, 0, 0, 0, 0, 32'h0,        32'h2008_0005, 32'hC,        32'h2008_0005, 32'hC,       1, 2'd0, 0);
    vecs[5]  = mk(1, 1, 1, 0, 0, 0, 0, 32'h0,        32'h2008_0005, 32'h10,       32'h2008_0005, 32'h10,      1, 2'd0, 0);
    vecs[6]  = mk(1, 0, 0, 1, 0, 0, 0, 32'h0,        32'h8C09_0000, 32'h10,       32'h2008_0005, 32'h10,      0, 2'd1, 0);
    vecs[7]  = mk(1, 1, 1, 0, 0, 0, 0, 32'h0,        32'h8C09_0000, 32'h14,       32'h8C09_0000, 32'h14,      1, 2'd0, 0);
    vecs[8]  = mk(0, 1, 1, 0, 0, 0, 0, 32'h0,        32'h0800_0040, 32'h0,        NOP,          32'h0,        0, 2'd0, 0);
    vecs[9]  = mk(1, 1, 0, 0, 0, 0, 0, 32'h0,        32'h0800_0040, 32'h4,        NOP,          32'h0,        1, 2'd0, 0);
    vecs[10] = mk(1, 1, 1, 0, 0, 0, 0, 32'h0,        32'h0800_0040, 32'h8,        32'h0800_0040, 32'h8,       1, 2'd0, 0);
    vecs[11] = mk(1, 1, 0, 0, 1, 1, 0, 32'h0,        32'h2008_0005, 32'h100,      NOP,          32'hC,        1, 2'd2, 0);
    vecs[12] = mk(1, 1, 1, 0, 0, 0, 0, 32'h0,        32'h2008_0005, 32'h104,      32'h2008_0005, 32'h104,     1, 2'd0, 0);
    vecs[13] = mk(1, 0, 0, 1, 1, 1, 1, 32'h40,       32'h2008_0005, 32'h40,       NOP,          32'h108,      0, 2'd2, 0);
    vecs[14] = mk(1, 1, 1, 0, 0, 0, 0, 32'h0,        32'h2008_0005, 32'h44,       32'h2008_0005, 32'h44,      1, 2'd0, 0);
    vecs[15] = mk(1, 1, 1, 0, 1, 1, 1, 32'hFFFF_FFFC, 32'h2008_0005, 32'hFFFF_FFFC, NOP,        32'h48,       0, 2'd2, 0);
    vecs[16] = mk(1, 1, 1, 0, 0, 0, 0, 32'h0,        32'h2008_0005, 32'h0,        32'h2008_0005, 32'h0,       1, 2'd0, 0);
    vecs[17] = mk(1, 0, 1, 0, 0, 0, 0, 32'h0,        32'h2008_0005, 32'h0,        32'h2008_0005, 32'h4,       1, 2'd1, 1);

    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].rst_n, vecs[i].pc_en, vecs[i].if_id_en, vecs[i].ctrl_sel,
                    vecs[i].instr_sel, vecs[i].redirect, vecs[i].bnj, vecs[i].target, vecs[i].imem);
      checkOutput($sformatf("vec%0d.pc", i),    imem_addr,   vecs[i].exp_pc);
      checkOutput($sformatf("vec%0d.ir", i),    if_id_ir,    vecs[i].exp_ir);
      checkOutput($sformatf("vec%0d.pc4", i),   if_id_pc4,   vecs[i].exp_pc4);
      checkOutput($sformatf("vec%0d.valid", i), {31'd0, id_ex_valid}, {31'd0, vecs[i].exp_valid});
      checkOutput($sformatf("vec%0d.state", i), {30'd0, state},       {30'd0, vecs[i].exp_state});
      checkOutput($sformatf("vec%0d.err", i),   {31'd0, proto_err},   {31'd0, vecs[i].exp_err});
    end

    // proto_err stays set through clean traffic and only reset clears it.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 1, 1, 0, 0, 0, 0, 32'h0, 32'h2008_0005);
      checkOutput($sformatf("sticky%0d.err", i), {31'd0, proto_err}, 32'd1);
    end
    applyStimulus(0, 1, 1, 0, 1, 1, 1, 32'h40, 32'h2008_0005);
    checkOutput("rst_clear.err",   {31'd0, proto_err}, 32'd0);
    checkOutput("rst_wins.pc",     imem_addr, 32'h0);
    checkOutput("rst_wins.state",  {30'd0, state}, 32'd0);

    // Multi-cycle stall: no instruction lost or duplicated.
    applyStimulus(1, 1, 1, 0, 0, 0, 0, 32'h0, 32'hAAAA_0001);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 0, 1, 0, 0, 0, 32'h0, 32'hBBBB_0002);
      checkOutput($sformatf("stall%0d.ir", i), if_id_ir, 32'hAAAA_0001);
      checkOutput($sformatf("stall%0d.pc", i), imem_addr, 32'h4);
    end
    applyStimulus(1, 1, 1, 1, 1, 1, 0, 32'h0, 32'hBBBB_0002);
    checkOutput("after_stall.jump_pc", imem_addr, {4'h0, 26'h2AA_0001 & 26'h3FF_FFFF, 2'b00});
    applyStimulus(1, 1, 1, 0, 1, 1, 1, 32'h200, 32'hBBBB_0002);
    checkOutput("redir_redir.state", {30'd0, state}, 32'd2);
`ifdef PIPE_PERF_CNT_EN
    checkOutput("perf.stall_cnt", stall_cnt, 32'd3);
    checkOutput("perf.flush_cnt", flush_cnt, 32'd2);
`endif

    // Random traffic against the model.
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 32'h0, 32'h0);
    modelStep(0, 1, 1, 0, 0, 0, 0, 32'h0, 32'h0);
    for (int i = 0; i < 600; i++) begin
      logic r, pe, ie, cs, is, rd, bj;
      logic [31:0] tg, im;
      r  = ($urandom_range(0, 40) != 0);
      pe = ($urandom_range(0, 4) != 0);
      ie = ($urandom_range(0, 15) == 0) ? ~pe : pe;
      rd = ($urandom_range(0, 7) == 0);
      bj = $urandom_range(0, 1);
      is = rd ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 9) == 0);
      cs = ($urandom_range(0, 5) == 0) || !pe;
      tg = {$urandom, 2'b00} >> 2 << 2;
      tg = $urandom & 32'hFFFF_FFFC;
      im = $urandom;
      applyStimulus(r, pe, ie, cs, is, rd, bj, tg, im);
      modelStep(r, pe, ie, cs, is, rd, bj, tg, im);
      checkOutput("rand.pc",    imem_addr, m_pc);
      checkOutput("rand.ir",    if_id_ir,  m_ir);
      checkOutput("rand.pc4",   if_id_pc4, m_pc4);
      checkOutput("rand.valid", {31'd0, id_ex_valid}, {31'd0, m_valid});
      checkOutput("rand.state", {30'd0, state}, m_mode);
      checkOutput("rand.err",   {31'd0, proto_err}, {31'd0, m_err});
`ifdef PIPE_PERF_CNT_EN
      checkOutput("rand.stall_cnt", stall_cnt, m_stall);
      checkOutput("rand.flush_cnt", flush_cnt, m_flush);
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
